// File: rtl/core_pkg.sv
// core_pkg: shared definitions for the 16-bit pipelined core.
//   DATA_W / REG_N / REG_ADDR_W : datapath width, register count, register address width
//   OP_*                        : major opcode encodings (instr[15:12])
//   ALU_*                       : ALU operation encodings seen by execute
//   ctrl_t                      : bundle of decoded control signals
package core_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned REG_N      = 8;
    localparam int unsigned REG_ADDR_W = 3;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_LW    = 4'h2;
    localparam logic [3:0] OP_SW    = 4'h3;
    localparam logic [3:0] OP_BEQ   = 4'h4;
    localparam logic [3:0] OP_JAL   = 4'h5;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SLL = 3'd5;
    localparam logic [2:0] ALU_SRL = 3'd6;
    localparam logic [2:0] ALU_SLT = 3'd7;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic [2:0] alu_ctrl;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/regfile.sv
// regfile: 8x16 architectural register file.
//   clk, rst      : clock, asynchronous active-high reset (clears every register)
//   ra1/ra2       : read addresses; rd1/rd2 combinational read data
//   we, wa, wd    : write port, written at posedge clk when we && wa != 0
// r0 always reads 0. A read of the register being written this cycle returns wd.
module regfile
    import core_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] ra1,
    input  logic [REG_ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0]     rd1,
    output logic [DATA_W-1:0]     rd2,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0]     wd
);

    logic [DATA_W-1:0] regs_q [REG_N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_N; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            regs_q[wa] <= wd;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [REG_ADDR_W-1:0] ra);
        logic [DATA_W-1:0] v;
        if (ra == '0) begin
            v = '0;
        end else if (we && (wa == ra)) begin
            v = wd;  // write-through so W-stage result is visible without a stall
        end else begin
            v = regs_q[ra];
        end
        return v;
    endfunction

    always_comb begin
        rd1 = read_port(ra1);
        rd2 = read_port(ra2);
    end

endmodule

// File: rtl/decode.sv
// decode: decode stage of the 16-bit pipelined core.
//   clk, rst             : clock, asynchronous active-high reset
//   stall_d, flush_e     : hold D/E register / insert bubble (flush wins)
//   instr_d, pc_d, pc_next_d : F/D register contents
//   wb_en_w, wb_addr_w, wb_data_w : register-file write port from writeback
//   *_e outputs          : D/E pipeline register (operands, immediate, addresses,
//                          PCs, control signals, illegal-opcode flag)
module decode
    import core_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_d,
    input  logic                  flush_e,
    input  logic [DATA_W-1:0]     instr_d,
    input  logic [DATA_W-1:0]     pc_d,
    input  logic [DATA_W-1:0]     pc_next_d,
    input  logic                  wb_en_w,
    input  logic [REG_ADDR_W-1:0] wb_addr_w,
    input  logic [DATA_W-1:0]     wb_data_w,
    output logic [DATA_W-1:0]     rd1_e,
    output logic [DATA_W-1:0]     rd2_e,
    output logic [DATA_W-1:0]     imm_e,
    output logic [REG_ADDR_W-1:0] rd_addr_e,
    output logic [REG_ADDR_W-1:0] rs1_addr_e,
    output logic [REG_ADDR_W-1:0] rs2_addr_e,
    output logic [DATA_W-1:0]     pc_e,
    output logic [DATA_W-1:0]     pc_next_e,
    output logic                  reg_write_e,
    output logic                  mem_read_e,
    output logic                  mem_write_e,
    output logic                  mem_to_reg_e,
    output logic                  alu_src_e,
    output logic                  branch_e,
    output logic                  jump_e,
    output logic [2:0]            alu_ctrl_e,
    output logic                  illegal_e
);

    function automatic ctrl_t decode_ctrl(input logic [3:0] op, input logic [2:0] funct);
        ctrl_t c;
        c = '0;
        c.alu_ctrl = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                c.reg_write = 1'b1;
                c.alu_ctrl  = funct;
            end
            OP_ADDI: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
            end
            OP_LW: begin
                c.reg_write  = 1'b1;
                c.mem_read   = 1'b1;
                c.mem_to_reg = 1'b1;
                c.alu_src    = 1'b1;
            end
            OP_SW: begin
                c.mem_write = 1'b1;
                c.alu_src   = 1'b1;
            end
            OP_BEQ: begin
                c.branch   = 1'b1;
                c.alu_ctrl = ALU_SUB;
            end
            OP_JAL: begin
                c.jump      = 1'b1;
                c.reg_write = 1'b1;
            end
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    logic [3:0]            op;
    logic [REG_ADDR_W-1:0] rd_f;
    logic [REG_ADDR_W-1:0] rs1_f;
    logic [REG_ADDR_W-1:0] rs2_f;
    logic [DATA_W-1:0]     imm;
    logic [DATA_W-1:0]     rd1;
    logic [DATA_W-1:0]     rd2;
    ctrl_t                 ctrl;

    always_comb begin
        op    = instr_d[15:12];
        rd_f  = instr_d[11:9];
        rs1_f = instr_d[8:6];
        // Stores and branches carry their second source in the rd field.
        rs2_f = ((op == OP_SW) || (op == OP_BEQ)) ? instr_d[11:9] : instr_d[5:3];
        ctrl  = decode_ctrl(op, instr_d[2:0]);
        case (op)
            OP_ADDI, OP_LW, OP_SW: imm = {{10{instr_d[5]}}, instr_d[5:0]};
            OP_BEQ:                imm = {{9{instr_d[5]}}, instr_d[5:0], 1'b0};
            OP_JAL:                imm = {{6{instr_d[8]}}, instr_d[8:0], 1'b0};
            default:               imm = '0;
        endcase
    end

    regfile u_regfile (
        .clk (clk),
        .rst (rst),
        .ra1 (rs1_f),
        .ra2 (rs2_f),
        .rd1 (rd1),
        .rd2 (rd2),
        .we  (wb_en_w),
        .wa  (wb_addr_w),
        .wd  (wb_data_w)
    );

    ctrl_t ctrl_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush_e) begin
            // flush_e is synchronous; rst is the only asynchronous term
            if (rst || flush_e) begin
                ctrl_q     <= '0;
                rd1_e      <= '0;
                rd2_e      <= '0;
                imm_e      <= '0;
                rd_addr_e  <= '0;
                rs1_addr_e <= '0;
                rs2_addr_e <= '0;
                pc_e       <= '0;
                pc_next_e  <= '0;
            end
        end else if (!stall_d) begin
            ctrl_q     <= ctrl;
            rd1_e      <= rd1;
            rd2_e      <= rd2;
            imm_e      <= imm;
            rd_addr_e  <= rd_f;
            rs1_addr_e <= rs1_f;
            rs2_addr_e <= rs2_f;
            pc_e       <= pc_d;
            pc_next_e  <= pc_next_d;
        end
    end

    always_comb begin
        reg_write_e  = ctrl_q.reg_write;
        mem_read_e   = ctrl_q.mem_read;
        mem_write_e  = ctrl_q.mem_write;
        mem_to_reg_e = ctrl_q.mem_to_reg;
        alu_src_e    = ctrl_q.alu_src;
        branch_e     = ctrl_q.branch;
        jump_e       = ctrl_q.jump;
        alu_ctrl_e   = ctrl_q.alu_ctrl;
        illegal_e    = ctrl_q.illegal;
    end

endmodule

// File: tb/tb_decode.sv
// tb_decode: scoreboard bench for decode. Stimulus pushes the expected D/E contents
// (value + care-mask) into a queue; a monitor pops and compares after every clock edge.
module tb_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_d, flush_e;
    logic [15:0] instr_d, pc_d, pc_next_d;
    logic        wb_en_w;
    logic [2:0]  wb_addr_w;
    logic [15:0] wb_data_w;
    logic [15:0] rd1_e, rd2_e, imm_e, pc_e, pc_next_e;
    logic [2:0]  rd_addr_e, rs1_addr_e, rs2_addr_e, alu_ctrl_e;
    logic        reg_write_e, mem_read_e, mem_write_e, mem_to_reg_e;
    logic        alu_src_e, branch_e, jump_e, illegal_e;

    always #5 clk = ~clk;

    decode dut (
        .clk          (clk),
        .rst          (rst),
        .stall_d      (stall_d),
        .flush_e      (flush_e),
        .instr_d      (instr_d),
        .pc_d         (pc_d),
        .pc_next_d    (pc_next_d),
        .wb_en_w      (wb_en_w),
        .wb_addr_w    (wb_addr_w),
        .wb_data_w    (wb_data_w),
        .rd1_e        (rd1_e),
        .rd2_e        (rd2_e),
        .imm_e        (imm_e),
        .rd_addr_e    (rd_addr_e),
        .rs1_addr_e   (rs1_addr_e),
        .rs2_addr_e   (rs2_addr_e),
        .pc_e         (pc_e),
        .pc_next_e    (pc_next_e),
        .reg_write_e  (reg_write_e),
        .mem_read_e   (mem_read_e),
        .mem_write_e  (mem_write_e),
        .mem_to_reg_e (mem_to_reg_e),
        .alu_src_e    (alu_src_e),
        .branch_e     (branch_e),
        .jump_e       (jump_e),
        .alu_ctrl_e   (alu_ctrl_e),
        .illegal_e    (illegal_e)
    );

    // Layout: rd1 rd2 imm rd rs1 rs2 pc pc_next rw mr mw m2r as br jp alu ill
    logic [99:0] act;
    assign act = {rd1_e, rd2_e, imm_e, rd_addr_e, rs1_addr_e, rs2_addr_e, pc_e, pc_next_e,
                  reg_write_e, mem_read_e, mem_write_e, mem_to_reg_e, alu_src_e,
                  branch_e, jump_e, alu_ctrl_e, illegal_e};

    typedef struct {
        logic [99:0] val;
        logic [99:0] msk;
    } exp_t;

    exp_t        q[$];
    exp_t        prev;
    logic [15:0] mregs [8];
    int          total = 0;
    int          bad = 0;

    function automatic logic [99:0] pack(
        input logic [15:0] rd1, input logic [15:0] rd2, input logic [15:0] imm,
        input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2,
        input logic [15:0] pc, input logic [15:0] pcn,
        input logic [6:0] ctl, input logic [2:0] alu, input logic ill);
        return {rd1, rd2, imm, rd, rs1, rs2, pc, pcn, ctl, alu, ill};
    endfunction

    // Register read as seen in the decode cycle, including the write-through path.
    function automatic logic [15:0] mread(input logic [2:0] a, input logic we,
                                          input logic [2:0] wa, input logic [15:0] wd);
        if (a == 3'd0) return 16'h0000;
        if (we && wa == a) return wd;
        return mregs[a];
    endfunction

    function automatic exp_t model(input logic [15:0] ins, input logic [15:0] pc,
                                   input logic we, input logic [2:0] wa,
                                   input logic [15:0] wd);
        exp_t e;
        int unsigned op, f_rd, f_rs1, f_rs2, funct, i6, i9;
        int s;
        logic [15:0] imm, rd1, rd2;
        logic [2:0]  rs2a;
        logic [6:0]  ctl;   // rw mr mw m2r as br jp
        logic [2:0]  alu;
        logic        ill;
        logic        c_imm, c_rd, c_rs2, c_src;
        op    = ins / 4096;
        f_rd  = (ins / 512) % 8;
        f_rs1 = (ins / 64) % 8;
        f_rs2 = (ins / 8) % 8;
        funct = ins % 8;
        i6    = ins % 64;
        i9    = ins % 512;
        imm = 16'h0; ctl = 7'b0; alu = 3'd0; ill = 1'b0;
        c_imm = 1'b1; c_rd = 1'b1; c_rs2 = 1'b1; c_src = 1'b1;
        rs2a = 3'(f_rs2);
        case (op)
            0: begin ctl = 7'b1000000; alu = 3'(funct); c_imm = 1'b0; end
            1: begin ctl = 7'b1000100; s = (i6 >= 32) ? int'(i6) - 64 : int'(i6);
                     imm = 16'(s); c_rs2 = 1'b0; end
            2: begin ctl = 7'b1101100; s = (i6 >= 32) ? int'(i6) - 64 : int'(i6);
                     imm = 16'(s); c_rs2 = 1'b0; end
            3: begin ctl = 7'b0010100; s = (i6 >= 32) ? int'(i6) - 64 : int'(i6);
                     imm = 16'(s); rs2a = 3'(f_rd); c_rd = 1'b0; end
            4: begin ctl = 7'b0000010; alu = 3'd1; s = (i6 >= 32) ? int'(i6) - 64 : int'(i6);
                     imm = 16'(s * 2); rs2a = 3'(f_rd); c_rd = 1'b0; end
            5: begin ctl = 7'b1000001; s = (i9 >= 256) ? int'(i9) - 512 : int'(i9);
                     imm = 16'(s * 2); c_rs2 = 1'b0; end
            default: begin ill = 1'b1; c_imm = 1'b0; c_rd = 1'b0; c_rs2 = 1'b0;
                           c_src = 1'b0; end
        endcase
        rd1 = mread(3'(f_rs1), we, wa, wd);
        rd2 = mread(rs2a, we, wa, wd);
        e.val = pack(rd1, rd2, imm, 3'(f_rd), 3'(f_rs1), rs2a, pc, pc + 16'd2, ctl, alu, ill);
        e.msk = pack({16{c_src}}, {16{c_rs2}}, {16{c_imm}}, {3{c_rd}}, {3{c_src}}, {3{c_rs2}},
                     16'hFFFF, 16'hFFFF, 7'h7F, 3'h7, 1'b1);
        return e;
    endfunction

    task automatic issue(input logic [15:0] ins, input logic [15:0] pc, input logic st,
                         input logic fl, input logic we, input logic [2:0] wa,
                         input logic [15:0] wd);
        exp_t e;
        @(negedge clk);
        instr_d = ins; pc_d = pc; pc_next_d = pc + 16'd2;
        stall_d = st; flush_e = fl;
        wb_en_w = we; wb_addr_w = wa; wb_data_w = wd;
        if (fl) begin
            e.val = '0;
            e.msk = '1;
        end else if (st) begin
            e = prev;
        end else begin
            e = model(ins, pc, we, wa, wd);
        end
        q.push_back(e);
        prev = e;
        if (we && wa != 3'd0) mregs[wa] = wd;
    endtask

    task automatic do_reset();
        @(negedge clk);
        instr_d = 16'h1205; stall_d = 1'b0; flush_e = 1'b0; wb_en_w = 1'b0;
        rst = 1'b1;
        #1;
        total++;
        if (act !== '0) begin
            bad++;
            $display("FAIL async_reset: got %h expected 0", act);
        end
        q.delete();
        prev.val = '0; prev.msk = '1;
        for (int i = 0; i < 8; i++) mregs[i] = 16'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic rand_cycles(input int n);
        logic [15:0] ins;
        for (int k = 0; k < n; k++) begin
            ins = 16'($urandom);
            if ($urandom_range(0, 3) != 0) ins[15:12] = 4'($urandom_range(0, 5));
            issue(ins, {15'($urandom), 1'b0}, ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1),
                  3'($urandom), 16'($urandom));
        end
    endtask

    // Monitor: compare after each edge outside reset.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && q.size() > 0) begin
                e = q.pop_front();
                total++;
                if ((act & e.msk) !== (e.val & e.msk)) begin
                    bad++;
                    $display("FAIL de_reg @%0t: got %h expected %h mask %h",
                             $time, act, e.val, e.msk);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; stall_d = 1'b0; flush_e = 1'b0;
        instr_d = 16'h0; pc_d = 16'h0; pc_next_d = 16'h0002;
        wb_en_w = 1'b0; wb_addr_w = 3'd0; wb_data_w = 16'h0;
        prev.val = '0; prev.msk = '1;
        for (int i = 0; i < 8; i++) mregs[i] = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        issue(16'h1205, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);      // ADDI r1,r0,5
        issue(16'h123F, 16'h0002, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);      // imm = -1
        issue(16'h04D8, 16'h0004, 1'b0, 1'b0, 1'b1, 3'd3, 16'hBEEF);   // bypass
        issue(16'h0418, 16'h0006, 1'b0, 1'b0, 1'b1, 3'd0, 16'h1234);   // write r0
        issue(16'h0418, 16'h0008, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);      // r0 reads 0
        issue(16'h5FFF, 16'h0010, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);      // JAL
        issue(16'h1205, 16'h0020, 1'b1, 1'b0, 1'b1, 3'd5, 16'h5555);   // stall
        issue(16'h3E3F, 16'h0022, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);      // stall
        issue(16'h0B68, 16'h0024, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);      // stalled write visible
        issue(16'h1205, 16'h0026, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0);      // flush wins
        issue(16'h7000, 16'h0028, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);      // illegal
        issue(16'h48FF, 16'h002A, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);      // BEQ
        issue(16'h2A41, 16'h002C, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);      // LW

        rand_cycles(300);

        issue(16'h1205, 16'h0100, 1'b0, 1'b0, 1'b1, 3'd4, 16'hCAFE);
        do_reset();
        for (int a = 1; a < 8; a++) begin
            issue({4'h0, 3'd0, 3'(a), 3'(a), 3'd0}, 16'h0200, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        end

        rand_cycles(200);

        @(negedge clk);
        stall_d = 1'b1; wb_en_w = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
